trd_sched: RTL

//  Per-thread PC register file and round-robin fetch scheduler for the 8-thread core.

---
 rtl/trd_sched.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/trd_sched.sv
// Per-thread PC register file and round-robin fetch scheduler.
// Each lane holds one thread's OFF/RDY/WAIT state and its PC. The top
// picks the next ready thread after the last one issued and registers
// cur_trd/cur_pc/i_rd toward the I-cache.

module trd_sched_lane #(
  parameter logic [31:0] START_PC = 32'h0001_0100,
  parameter bit          RST_RDY  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        kill_i,
  input  logic        miss_i,
  input  logic        fill_i,
  input  logic        start_i,
  input  logic        pc_wr_i,
  input  logic [31:0] nxt_pc_i,
  output logic        cand_o,
  output logic [31:0] pc_o,
  output logic        active_o
);
  typedef enum logic [1:0] {ST_OFF = 2'd0, ST_RDY = 2'd1, ST_WAIT = 2'd2} st_e;
  localparam st_e ST_RST = RST_RDY ? ST_RDY : ST_OFF;

  st_e         st_q, st_d;
  logic [31:0] pc_q;
  logic        active_q;

  // Thread state transitions: kill > miss > fill > start.
  always_comb begin
    st_d = st_q;
    if (kill_i)                            st_d = ST_OFF;
    else if (miss_i && st_q != ST_OFF)     st_d = ST_WAIT;
    else if (fill_i && st_q == ST_WAIT)    st_d = ST_RDY;
    else if (start_i && st_q == ST_OFF)    st_d = ST_RDY;
  end

  // State, PC and the registered active flag; PC writes ignore state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= ST_RST;
      pc_q     <= START_PC;
      active_q <= RST_RDY;
    end else begin
      st_q     <= st_d;
      active_q <= (st_d != ST_OFF);
      if (pc_wr_i) pc_q <= nxt_pc_i;
    end
  end

  // A thread killed or missing this cycle must not win arbitration.
  assign cand_o   = (st_q == ST_RDY) && !kill_i && !miss_i;
  assign pc_o     = pc_q;
  assign active_o = active_q;
endmodule

module trd_sched #(
  parameter int          NUM_TRD  = 8,
  parameter logic [31:0] START_PC = 32'h0001_0100
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [32*NUM_TRD-1:0]   nxt_pc_flat_i,
  input  logic [NUM_TRD-1:0]      pc_wr_i,
  input  logic                    i_miss_i,
  input  logic [2:0]              i_miss_trd_i,
  input  logic                    d_miss_i,
  input  logic [2:0]              d_miss_trd_i,
  input  logic                    fill_done_i,
  input  logic [2:0]              fill_trd_i,
  input  logic [NUM_TRD-1:0]      trd_start_i,
  input  logic [NUM_TRD-1:0]      trd_kill_i,
  input  logic                    stall_i,
  output logic [2:0]              cur_trd_o,
  output logic [31:0]             cur_pc_o,
  output logic                    i_rd_o,
  output logic [NUM_TRD-1:0]      trd_active_o
);
  localparam int TW = $clog2(NUM_TRD);

  logic [NUM_TRD-1:0][31:0] nxt_pc, pc;
  logic [NUM_TRD-1:0]       miss, fill, cand;

  // cur_trd_q doubles as last_trd: both only change together on issue.
  logic [TW-1:0] cur_trd_q, cur_trd_d;
  logic [31:0]   cur_pc_q, cur_pc_d;
  logic          i_rd_q, i_rd_d;
  logic [TW-1:0] win;
  logic          found;

  assign nxt_pc = nxt_pc_flat_i;

  for (genvar g = 0; g < NUM_TRD; g++) begin : g_lane
    // A same-thread i_miss and d_miss simply OR into one miss.
    assign miss[g] = (i_miss_i && i_miss_trd_i == TW'(g)) ||
                     (d_miss_i && d_miss_trd_i == TW'(g));
    assign fill[g] = fill_done_i && fill_trd_i == TW'(g);

    trd_sched_lane #(.START_PC(START_PC), .RST_RDY(g == 0)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .kill_i   (trd_kill_i[g]),
      .miss_i   (miss[g]),
      .fill_i   (fill[g]),
      .start_i  (trd_start_i[g]),
      .pc_wr_i  (pc_wr_i[g]),
      .nxt_pc_i (nxt_pc[g]),
      .cand_o   (cand[g]),
      .pc_o     (pc[g]),
      .active_o (trd_active_o[g])
    );
  end

  // Round-robin search starting after the last issued thread, ending on it.
  always_comb begin
    found = 1'b0;
    win   = cur_trd_q;
    for (int k = 1; k <= NUM_TRD; k++) begin
      logic [TW-1:0] idx;
      idx = TW'((int'(cur_trd_q) + k) % NUM_TRD);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Issue next state; stall freezes everything, bypass a same-cycle PC write.
  always_comb begin
    cur_trd_d = cur_trd_q;
    cur_pc_d  = cur_pc_q;
    i_rd_d    = i_rd_q;
    if (!stall_i) begin
      i_rd_d = found;
      if (found) begin
        cur_trd_d = win;
        cur_pc_d  = pc_wr_i[win] ? nxt_pc[win] : pc[win];
      end
    end
  end

  // Issued-thread output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_trd_q <= '0;
      cur_pc_q  <= START_PC;
      i_rd_q    <= 1'b0;
    end else begin
      cur_trd_q <= cur_trd_d;
      cur_pc_q  <= cur_pc_d;
      i_rd_q    <= i_rd_d;
    end
  end

  assign cur_trd_o = 3'(cur_trd_q);
  assign cur_pc_o  = cur_pc_q;
  assign i_rd_o    = i_rd_q;
endmodule
